// File: rtl/booth_pkg.sv
//==============================================================================
// Module      : booth_pkg
// Description : Shared types and constants for the radix-4 Booth multiplier.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Booth digit encoded as {zero, two, neg}
    localparam logic [2:0] DIG_ZERO = 3'b100;
    localparam logic [2:0] DIG_P1   = 3'b000;
    localparam logic [2:0] DIG_P2   = 3'b010;
    localparam logic [2:0] DIG_M1   = 3'b001;
    localparam logic [2:0] DIG_M2   = 3'b011;

    function automatic int iter_count(input int width);
        return width / 2 + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_r4_enc.sv
//==============================================================================
// Module      : booth_r4_enc
// Description : Radix-4 Booth recoder; 3-bit window to {zero, two, neg}.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0] win_i,
    output logic       zero_o,
    output logic       two_o,
    output logic       neg_o
);

    logic [2:0] w_dig;

    always_comb begin
        w_dig = DIG_ZERO;
        case (win_i)
            3'b000:  w_dig = DIG_ZERO;
            3'b001:  w_dig = DIG_P1;
            3'b010:  w_dig = DIG_P1;
            3'b011:  w_dig = DIG_P2;
            3'b100:  w_dig = DIG_M2;
            3'b101:  w_dig = DIG_M1;
            3'b110:  w_dig = DIG_M1;
            default: w_dig = DIG_ZERO;
        endcase
    end

    assign zero_o = w_dig[2];
    assign two_o  = w_dig[1];
    assign neg_o  = w_dig[0];

endmodule

`default_nettype wire

// File: rtl/booth_r4_seq_mult.sv
//==============================================================================
// Module      : booth_r4_seq_mult
// Description : Sequential radix-4 Booth multiplier, signed/unsigned at runtime,
//               valid/ready on both sides. Define BOOTH_MAG_EN for |product|.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [2*WIDTH-1:0]   magnitude,
    output logic                 busy
);

    localparam int ITER  = iter_count(WIDTH);
    localparam int E     = WIDTH + 2;
    localparam int AW    = E + 2;
    localparam int RW    = AW + E + 1;
    localparam int CNT_W = $clog2(ITER);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [AW-1:0]      acc_q;
    logic [E-1:0]       mplr_q;
    logic               guard_q;
    logic [E-1:0]       mcand_q;
    logic [2*WIDTH-1:0] product_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic               w_zero;
    logic               w_two;
    logic               w_neg;
    logic [E-1:0]       w_a_ext;
    logic [E-1:0]       w_b_ext;
    logic [AW-1:0]      w_m_ext;
    logic [AW-1:0]      w_m_sel;
    logic [AW-1:0]      w_addend;
    logic [AW-1:0]      w_sum;
    logic [RW-1:0]      w_full;
    logic [RW-1:0]      w_shift;
    logic [AW-1:0]      acc_d;
    logic [E-1:0]       mplr_d;
    logic               guard_d;
    logic [2*WIDTH-1:0] product_d;

    booth_r4_enc u_enc (
        .win_i  ({mplr_q[1:0], guard_q}),
        .zero_o (w_zero),
        .two_o  (w_two),
        .neg_o  (w_neg)
    );

    // Unsigned operands get two zero bits so the top Booth digit is never negative
    assign w_a_ext = {{2{a[WIDTH-1] & signed_mode}}, a};
    assign w_b_ext = {{2{b[WIDTH-1] & signed_mode}}, b};

    assign w_m_ext  = {{2{mcand_q[E-1]}}, mcand_q};
    assign w_m_sel  = w_two ? {w_m_ext[AW-2:0], 1'b0} : w_m_ext;
    assign w_addend = w_zero ? '0 : (w_neg ? (~w_m_sel + AW'(1)) : w_m_sel);
    assign w_sum    = acc_q + w_addend;
    assign w_full   = {w_sum, mplr_q, guard_q};
    assign w_shift  = {{2{w_full[RW-1]}}, w_full[RW-1:2]};

    assign acc_d     = w_shift[RW-1:E+1];
    assign mplr_d    = w_shift[E:1];
    assign guard_d   = w_shift[0];
    assign product_d = w_shift[2*WIDTH:1];

`ifdef BOOTH_MAG_EN
    logic               sign_q;
    logic [2*WIDTH-1:0] mag_q;
    logic [2*WIDTH-1:0] mag_d;

    assign mag_d = (sign_q && product_d[2*WIDTH-1]) ? (~product_d + (2*WIDTH)'(1))
                                                    : product_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && in_valid && in_ready_q) begin
                sign_q <= signed_mode;
            end
            if (state_q == ST_RUN && cnt_q == CNT_W'(ITER - 1)) begin
                mag_q <= mag_d;
            end
        end
    end

    assign magnitude = mag_q;
`else
    assign magnitude = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mplr_q      <= '0;
            guard_q     <= 1'b0;
            mcand_q     <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= ST_RUN;
                        cnt_q      <= '0;
                        acc_q      <= '0;
                        mplr_q     <= w_b_ext;
                        guard_q    <= 1'b0;
                        mcand_q    <= w_a_ext;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    mplr_q  <= mplr_d;
                    guard_q <= guard_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q     <= ST_DONE;
                        product_q   <= product_d;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_r4_seq_mult.sv
//==============================================================================
// Module      : tb_booth_r4_seq_mult
// Description : Scoreboard bench for booth_r4_seq_mult (WIDTH=32).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_booth_r4_seq_mult;

    localparam int W    = 32;
    localparam int ITER = W / 2 + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          signed_mode = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*W-1:0] product;
    logic [2*W-1:0] magnitude;
    logic          busy;

    booth_r4_seq_mult #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .magnitude   (magnitude),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] prod;
        logic [63:0] mag;
        int          acc_cyc;
        int          bp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_hs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input bit sm, input int c, input int bp);
        exp_t        e;
        longint      sx, sy;
        longint unsigned ux, uy;
        logic [63:0] p;
        if (sm) begin
            sx = longint'(signed'(x));
            sy = longint'(signed'(y));
            p  = 64'(sx * sy);
        end else begin
            ux = {32'd0, x};
            uy = {32'd0, y};
            p  = 64'(ux * uy);
        end
        e.prod = p;
`ifdef BOOTH_MAG_EN
        e.mag = (sm && $signed(p) < 0) ? 64'(-$signed(p)) : p;
`else
        e.mag = 64'd0;
`endif
        e.acc_cyc = c;
        e.bp      = bp;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: owns out_ready, pops the scoreboard on each handshake
    bit   seen = 0;
    bit   post_hs = 0;
    int   wait_cnt = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (rst) begin
            seen      = 0;
            post_hs   = 0;
            out_ready = 1'b0;
        end else begin
            if (post_hs) begin
                chk("in_ready_after_hs", 64'(in_ready), 64'd1);
                chk("out_valid_drop", 64'(out_valid), 64'd0);
                post_hs = 0;
            end
            if (busy || out_valid)
                chk("in_ready_low_busy", 64'(in_ready), 64'd0);
            if (out_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: product %h with empty scoreboard", product);
                        cur.prod = product; cur.mag = magnitude; cur.acc_cyc = cyc - ITER - 1; cur.bp = 0;
                    end else begin
                        cur = sb[0];
                    end
                    chk("latency", 64'(cyc - cur.acc_cyc), 64'(ITER + 1));
                    seen     = 1;
                    wait_cnt = cur.bp;
                end
                chk("product", product, cur.prod);
                chk("magnitude", magnitude, cur.mag);
                if (wait_cnt == 0) begin
                    out_ready   = 1'b1;
                    last_hs_cyc = cyc;
                    if (sb.size() > 0) void'(sb.pop_front());
                    seen    = 0;
                    post_hs = 1;
                end else begin
                    out_ready = 1'b0;
                    wait_cnt--;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit sm,
                         input int bp, input bit keep, output int acc_c);
        int g = 0;
        acc_c = -1;
        @(negedge clk);
        a = x; b = y; signed_mode = sm; in_valid = 1'b1;
        while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready %0b after %0d cycles, required 1", in_ready, g);
            in_valid = 1'b0;
            return;
        end
        acc_c = cyc;
        sb.push_back(model(x, y, sm, cyc, bp));
        @(posedge clk);
        #1;
        a = $urandom; b = $urandom; signed_mode = 1'($urandom);
        in_valid = keep;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
        case ($urandom_range(0, 3))
            0:       return corners[$urandom_range(0, 4)];
            1:       return 32'($signed($urandom_range(0, 200)) - 100);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ac;
        int g;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_magnitude", magnitude, 64'd0);

        issue(32'hFFFF_FFF9, 32'd3, 1'b1, 0, 1'b0, ac);
        issue(32'd16777215, 32'd16777215, 1'b1, 1, 1'b0, ac);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, ac);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, ac);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 2, 1'b0, ac);

        // Back-pressure with in_valid held through RUN and DONE
        issue(32'd2, 32'd15, 1'b1, 5, 1'b1, ac);
        issue(32'd5, 32'd6, 1'b0, 0, 1'b0, ac);
        chk("accept_after_hs", 64'(ac), 64'(last_hs_cyc + 1));

        // Abort mid-run at iteration 4
        issue(32'hFFFF_FFF9, 32'd7, 1'b1, 0, 1'b0, ac);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if (sb.size() > 0) void'(sb.pop_back());
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_product", product, 64'd0);
        chk("abort_magnitude", magnitude, 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        issue(32'hFFFF_FFF9, 32'd7, 1'b1, 0, 1'b0, ac);

        for (int i = 0; i < 40; i++) begin
            issue(pick_operand(), pick_operand(), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom), ac);
        end

        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while ((sb.size() != 0 || out_valid) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
Sequential radix-4 Booth multiplier, parametrised in operand width, with a runtime signed/unsigned mode. It supersedes the combinational radix-2 multiplier, retiring two multiplier bits per clock. It has valid/ready handshakes on both sides so it can sit between pipeline stages of the datapath. Outputs are the two's-complement product and its absolute magnitude.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4. Product and magnitude are 2*WIDTH bits.
ITER, WIDTH/2+1, derived localparam; number of radix-4 iterations. Not overridable.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands and mode present
in_ready  out  1  block can accept operands (IDLE only)
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
signed_mode  in  1  1 = a and b are two's complement; 0 = unsigned
out_valid  out  1  product and magnitude valid
out_ready  in  1  consumer accepts result
product  out  2*WIDTH  a*b, two's complement (signed mode) or unsigned
magnitude  out  2*WIDTH  |product|
busy  out  1  high in RUN or DONE

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset: state=IDLE; in_ready=1 on the cycle after reset deasserts; out_valid=0, busy=0, product=0, magnitude=0; all internal registers cleared.
- States and transitions:
  - IDLE -> RUN on in_valid&in_ready.
  - RUN -> DONE after exactly ITER cycles, tracked by an iteration counter 0..ITER-1.
  - DONE -> IDLE on out_valid&out_ready.
- Capture on accept: operands are extended to E=WIDTH+2 bits. In signed mode they are sign-extended; in unsigned mode they are zero-extended. signed_mode is latched on accept and held.
- Accumulator layout: {acc[E+1:0], mplr[E-1:0], guard}, with guard=0.
- Each RUN cycle:
  - Decode the Booth digit {mplr[1:0],guard} to one of {0, +M, +2M, -M, -2M}.
  - Add the digit to acc using E+2-bit arithmetic.
  - Arithmetic-shift the whole register right by 2.
- Result: product = low 2*WIDTH bits of {acc,mplr} after the last iteration. It is registered on entry to DONE.
- Magnitude:
  - signed mode: magnitude = product[2W-1] ? -product : product. -(2^(W-1))^2 = 2^(2W-2) fits, so there is no overflow case.
  - unsigned mode: magnitude = product.
- Latency: accept at cycle 0 -> out_valid high at cycle ITER+1 (cycle 18 for WIDTH=32).
- Output hold: product and magnitude hold stable while out_valid=1 and out_ready=0. After the handshake they keep their last value; out_valid drops.
- in_ready is 0 in RUN and DONE. in_valid during those states is ignored; no queuing.
- in_ready returns to 1 on the cycle after the output handshake. There is no same-cycle accept in DONE.
- rst mid-RUN or mid-DONE aborts the operation: next cycle is IDLE with the reset values and no out_valid pulse.
- Operand inputs are sampled only on the accept cycle; changes during RUN have no effect.

Optional Feature:
BOOTH_MAG_EN
- Defined: magnitude is computed and registered as above.
- Undefined: the magnitude output is tied to 0, and the negation logic and register are removed. product, handshake and latency are unchanged.

Decomposition:
- Package booth_pkg:
  - state enum {ST_IDLE, ST_RUN, ST_DONE};
  - Booth digit encoding constants (DIG_ZERO, DIG_P1, DIG_P2, DIG_M1, DIG_M2);
  - function returning the iteration count for a width.
- Sub-module booth_r4_enc: combinational; 3-bit window in; {zero, two, neg} out. Used once by the datapath.

Test Plan:
- Signed multiply: WIDTH=32, signed_mode=1, a=-7, b=3. Required: product=0xFFFFFFFFFFFFFFEB, magnitude=21, out_valid exactly 18 cycles after accept.
- Large signed operands: signed_mode=1, a=b=16777215. Required: product=magnitude=0x0000FFFFFE000001.
- Unsigned full scale: signed_mode=0, a=b=0xFFFFFFFF. Required: product=0xFFFFFFFE00000001.
- Same bits in signed mode: a=b=0xFFFFFFFF with signed_mode=1. Required: product=1.
- Signed corner: signed_mode=1, a=b=0x80000000. Required: product=magnitude=0x4000000000000000.
- Back-pressure and ignored input: a=2, b=15, with out_ready held 0 for 5 cycles and in_valid held 1 during RUN and DONE. Required:
  - product=30 stays stable;
  - in_ready=0 until the cycle after out_ready=1;
  - the next operands are accepted only then.
- Reset mid-run: assert rst at iteration 4 of a=-7, b=7. Required:
  - next cycle out_valid=0, product=0, in_ready=1;
  - a following accept of -7*7 gives product=-49, magnitude=49.
- Optional feature off: with BOOTH_MAG_EN undefined, the a=-7, b=3 case gives magnitude=0 and the same product.
